ship_place_seq: RTL and testbench

- Sequences the ship-placement phase of the battleship game.
- Clears the player's board occupancy RAM, then accepts grid clicks from the mouse/grid decoder.
- For each click it checks bounds, checks collisions by reading the RAM, and writes the ship's cells.
- It steps through SHIP_CNT ships of decreasing length, then asserts done to the game FSM.
- It is the sole master of the board RAM port during placement.

---
 rtl/statki_pkg.sv | 37 +++
 rtl/ship_place_seq_if.sv | 26 ++
 rtl/ship_place_seq.sv | 167 ++++++++++++++++
 tb/tb_ship_place_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/statki_pkg.sv
// Shared constants, types and helpers for the ship-placement sequencer.
package statki_pkg;

    localparam int unsigned GRID_W   = 10;
    localparam int unsigned GRID_H   = 10;
    localparam int unsigned MAX_LEN  = 4;
    localparam int unsigned SHIP_CNT = 4;
    localparam int unsigned CELLS    = GRID_W * GRID_H;

    typedef enum logic {
        HORIZ = 1'b0,
        VERT  = 1'b1
    } orient_t;

    typedef enum logic [3:0] {
        StIdle,
        StClear,
        StWaitClick,
        StBounds,
        StCheck,
        StCheckLast,
        StWrite,
        StNext,
        StDone
    } place_state_t;

    // Linear RAM address of grid cell (x, y), row-major.
    function automatic logic [6:0] cell_addr(input logic [3:0] x, input logic [3:0] y);
        return 7'(int'(y) * GRID_W + int'(x));
    endfunction

    // Ships shrink by one cell per index, starting at MAX_LEN.
    function automatic logic [2:0] ship_len_of(input logic [1:0] idx);
        return 3'(MAX_LEN - int'(idx));
    endfunction

endpackage

// File: rtl/ship_place_seq_if.sv
// Board occupancy RAM port: the sequencer is master, the RAM is slave.
interface ship_place_seq_if;

    logic [6:0] board_addr;
    logic       board_re;
    logic       board_rd_data;
    logic       board_we;
    logic       board_wdata;

    modport master (
        output board_addr,
        output board_re,
        input  board_rd_data,
        output board_we,
        output board_wdata
    );

    modport slave (
        input  board_addr,
        input  board_re,
        output board_rd_data,
        input  board_we,
        input  board_wdata
    );

endinterface

// File: rtl/ship_place_seq.sv
// Ship-placement sequencer: clears the board RAM, then bounds-checks,
// collision-checks and writes each clicked ship until all are placed.
module ship_place_seq
    import statki_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cell_valid,
    input  logic [3:0]       cell_x,
    input  logic [3:0]       cell_y,
    input  logic             orient,
    ship_place_seq_if.master board,
    output logic             busy,
    output logic             reject,
    output logic [1:0]       ship_idx,
    output logic [2:0]       ship_len,
    output logic             done
);

    place_state_t state;
    logic [3:0]   x_q;
    logic [3:0]   y_q;
    orient_t      orient_q;
    logic [2:0]   k_q;
    logic         hit_q;

    logic [6:0]   addr_q;
    logic         re_q;
    logic         we_q;
    logic         wdata_q;

    logic [4:0]   end_x;
    logic [4:0]   end_y;
    logic         oob;
    logic         last_k;
    logic [6:0]   step;

    assign board.board_addr  = addr_q;
    assign board.board_re    = re_q;
    assign board.board_we    = we_q;
    assign board.board_wdata = wdata_q;

    // Bounds test on 5-bit sums so x + len cannot wrap; cell iterator helpers.
    always_comb begin
        end_x  = {1'b0, x_q} + {2'b00, ship_len};
        end_y  = {1'b0, y_q} + {2'b00, ship_len};
        oob    = (x_q >= 4'(GRID_W)) || (y_q >= 4'(GRID_H)) ||
                 ((orient_q == HORIZ) ? (end_x > 5'(GRID_W)) : (end_y > 5'(GRID_H)));
        last_k = (k_q == (ship_len - 3'd1));
        step   = (orient_q == VERT) ? 7'(GRID_W) : 7'd1;
    end

    // Placement FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            orient_q <= HORIZ;
            k_q      <= '0;
            hit_q    <= 1'b0;
            addr_q   <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= 1'b0;
            busy     <= 1'b0;
            reject   <= 1'b0;
            ship_idx <= '0;
            ship_len <= ship_len_of(2'd0);
            done     <= 1'b0;
        end else begin
            reject <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state    <= StClear;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        addr_q   <= '0;
                        we_q     <= 1'b1;
                        wdata_q  <= 1'b0;
                        ship_idx <= '0;
                        ship_len <= ship_len_of(2'd0);
                    end
                end
                StClear: begin
                    if (addr_q == 7'(CELLS - 1)) begin
                        state  <= StWaitClick;
                        we_q   <= 1'b0;
                        addr_q <= '0;
                    end else begin
                        addr_q <= addr_q + 7'd1;
                    end
                end
                StWaitClick: begin
                    if (cell_valid) begin
                        x_q      <= cell_x;
                        y_q      <= cell_y;
                        orient_q <= orient_t'(orient);
                        state    <= StBounds;
                    end
                end
                StBounds: begin
                    if (oob) begin
                        reject <= 1'b1;
                        state  <= StWaitClick;
                    end else begin
                        state  <= StCheck;
                        re_q   <= 1'b1;
                        addr_q <= cell_addr(x_q, y_q);
                        k_q    <= '0;
                        hit_q  <= 1'b0;
                    end
                end
                StCheck: begin
                    // Data returned now belongs to the read issued last cycle.
                    if (k_q != 3'd0) begin
                        hit_q <= hit_q | board.board_rd_data;
                    end
                    if (last_k) begin
                        state <= StCheckLast;
                        re_q  <= 1'b0;
                    end else begin
                        k_q    <= k_q + 3'd1;
                        addr_q <= addr_q + step;
                    end
                end
                StCheckLast: begin
                    if (hit_q || board.board_rd_data) begin
                        reject <= 1'b1;
                        state  <= StWaitClick;
                    end else begin
                        state   <= StWrite;
                        we_q    <= 1'b1;
                        wdata_q <= 1'b1;
                        addr_q  <= cell_addr(x_q, y_q);
                        k_q     <= '0;
                    end
                end
                StWrite: begin
                    if (last_k) begin
                        state   <= StNext;
                        we_q    <= 1'b0;
                        wdata_q <= 1'b0;
                    end else begin
                        k_q    <= k_q + 3'd1;
                        addr_q <= addr_q + step;
                    end
                end
                StNext: begin
                    if (ship_idx == 2'(SHIP_CNT - 1)) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        ship_idx <= ship_idx + 2'd1;
                        ship_len <= ship_len_of(ship_idx + 2'd1);
                        state    <= StWaitClick;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ship_place_seq.sv
// Directed bench for ship_place_seq with a behavioural board RAM.
module tb_ship_place_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cell_valid;
    logic [3:0] cell_x;
    logic [3:0] cell_y;
    logic       orient;
    logic       busy;
    logic       reject;
    logic [1:0] ship_idx;
    logic [2:0] ship_len;
    logic       done;
    logic       ram_fill;

    int n_cmp;
    int n_bad;

    logic       mem [0:127];
    logic       r_re  [0:15];
    logic       r_we  [0:15];
    logic       r_wd  [0:15];
    logic       r_rej [0:15];
    logic [6:0] r_addr [0:15];

    ship_place_seq_if bus ();

    ship_place_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cell_valid (cell_valid),
        .cell_x     (cell_x),
        .cell_y     (cell_y),
        .orient     (orient),
        .board      (bus.master),
        .busy       (busy),
        .reject     (reject),
        .ship_idx   (ship_idx),
        .ship_len   (ship_len),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board RAM: one-cycle read latency; prefilled with ones so a missing clear shows up.
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 128; i++) mem[i] <= 1'b1;
        end else begin
            if (bus.board_we) mem[bus.board_addr] <= bus.board_wdata;
            if (bus.board_re) bus.board_rd_data <= mem[bus.board_addr];
        end
    end

    function automatic int ones_in_board();
        int n = 0;
        for (int i = 0; i < 100; i++) n += (mem[i] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    // Pulses a click and records strobes for offsets 1..ncyc after the click cycle.
    task automatic do_click(input logic [3:0] x, input logic [3:0] y, input logic o,
                            input int ncyc);
        cell_x = x;
        cell_y = y;
        orient = o;
        cell_valid = 1'b1;
        @(negedge clk);
        cell_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            r_re[c]   = bus.board_re;
            r_we[c]   = bus.board_we;
            r_wd[c]   = bus.board_wdata;
            r_rej[c]  = reject;
            r_addr[c] = bus.board_addr;
            if (c < ncyc) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ram_fill = 1'b1;
        start = 1'b0;
        cell_valid = 1'b0;
        cell_x = '0;
        cell_y = '0;
        orient = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, reject, done, ship_idx, ship_len} !== {3'b000, 2'd0, 3'd4}) begin
            n_bad++;
            $display("FAIL reset_status got busy/rej/done/idx/len=%b%b%b/%0d/%0d want 000/0/4",
                     busy, reject, done, ship_idx, ship_len);
        end
        n_cmp++;
        if ({bus.board_re, bus.board_we, bus.board_wdata, bus.board_addr} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_bus got re/we/wd/addr=%b%b%b/%0d want 000/0",
                     bus.board_re, bus.board_we, bus.board_wdata, bus.board_addr);
        end
        rst = 1'b1;
        ram_fill = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, bus.board_re, bus.board_we, done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_quiet got busy/re/we/done=%b%b%b%b want 0000",
                     busy, bus.board_re, bus.board_we, done);
        end
    endtask

    task automatic test_clear();
        int errs = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.board_we !== 1'b1 || bus.board_wdata !== 1'b0 || bus.board_re !== 1'b0 ||
                bus.board_addr !== 7'(i)) begin
                if (errs < 4) begin
                    $display("FAIL clear_cycle i=%0d got we/wd/re/addr=%b%b%b/%0d want 100/%0d",
                             i, bus.board_we, bus.board_wdata, bus.board_re, bus.board_addr, i);
                end
                errs++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (errs != 0) n_bad++;
        n_cmp++;
        if ({bus.board_we, busy, reject, ship_idx, ship_len} !== {1'b0, 1'b1, 1'b0, 2'd0, 3'd4}) begin
            n_bad++;
            $display("FAIL after_clear got we/busy/rej/idx/len=%b%b%b/%0d/%0d want 010/0/4",
                     bus.board_we, busy, reject, ship_idx, ship_len);
        end
        n_cmp++;
        if (ones_in_board() != 0) begin
            n_bad++;
            $display("FAIL clear_ram got %0d occupied cells want 0", ones_in_board());
        end
    endtask

    // Accepted placement: reads then writes of cells base + k*step, then index/done update.
    task automatic test_place_ship(input string nm, input logic [3:0] x, input logic [3:0] y,
                                   input logic o, input int len, input int base, input int step,
                                   input logic [1:0] idx_exp, input logic [2:0] len_exp,
                                   input logic done_exp);
        logic e_re;
        logic e_we;
        logic [6:0] e_a;
        do_click(x, y, o, 2 * len + 4);
        for (int c = 1; c <= 2 * len + 3; c++) begin
            e_re = (c >= 2) && (c <= len + 1);
            e_we = (c >= len + 3) && (c <= 2 * len + 2);
            if (e_re) e_a = 7'(base + (c - 2) * step);
            else if (e_we) e_a = 7'(base + (c - len - 3) * step);
            else e_a = '0;
            n_cmp++;
            if ({r_re[c], r_we[c], r_rej[c]} !== {e_re, e_we, 1'b0}) begin
                n_bad++;
                $display("FAIL %s_strobe c=%0d got re/we/rej=%b%b%b want %b%b0",
                         nm, c, r_re[c], r_we[c], r_rej[c], e_re, e_we);
            end
            if (e_re || e_we) begin
                n_cmp++;
                if (r_addr[c] !== e_a || (e_we && r_wd[c] !== 1'b1)) begin
                    n_bad++;
                    $display("FAIL %s_addr c=%0d got addr/wd=%0d/%b want %0d/%b",
                             nm, c, r_addr[c], r_wd[c], e_a, e_we);
                end
            end
        end
        n_cmp++;
        if ({ship_idx, ship_len, done, busy} !== {idx_exp, len_exp, done_exp, ~done_exp}) begin
            n_bad++;
            $display("FAIL %s_next got idx/len/done/busy=%0d/%0d/%b%b want %0d/%0d/%b%b",
                     nm, ship_idx, ship_len, done, busy, idx_exp, len_exp, done_exp, ~done_exp);
        end
    endtask

    // Refused click: reads (if any) are issued, never a write, a single reject pulse.
    task automatic test_reject(input string nm, input logic [3:0] x, input logic [3:0] y,
                               input logic o, input int len, input int reads, input int base,
                               input int step, input logic [1:0] idx_exp);
        int rej_off;
        logic e_re;
        rej_off = (reads == 0) ? 2 : len + 3;
        do_click(x, y, o, rej_off + 1);
        for (int c = 1; c <= rej_off + 1; c++) begin
            e_re = (reads != 0) && (c >= 2) && (c <= len + 1);
            n_cmp++;
            if ({r_re[c], r_we[c], r_rej[c]} !== {e_re, 1'b0, (c == rej_off)}) begin
                n_bad++;
                $display("FAIL %s_strobe c=%0d got re/we/rej=%b%b%b want %b0%b",
                         nm, c, r_re[c], r_we[c], r_rej[c], e_re, (c == rej_off));
            end
            if (e_re) begin
                n_cmp++;
                if (r_addr[c] !== 7'(base + (c - 2) * step)) begin
                    n_bad++;
                    $display("FAIL %s_addr c=%0d got %0d want %0d",
                             nm, c, r_addr[c], base + (c - 2) * step);
                end
            end
        end
        n_cmp++;
        if ({ship_idx, busy} !== {idx_exp, 1'b1}) begin
            n_bad++;
            $display("FAIL %s_idx got idx/busy=%0d/%b want %0d/1", nm, ship_idx, busy, idx_exp);
        end
    endtask

    task automatic test_done_ignore();
        int errs = 0;
        do_click(4'd1, 4'd1, 1'b0, 8);
        for (int c = 1; c <= 8; c++) begin
            if (r_re[c] !== 1'b0 || r_we[c] !== 1'b0 || r_rej[c] !== 1'b0) errs++;
        end
        n_cmp++;
        if (errs != 0 || done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done_ignore got %0d active cycles done/busy=%b%b want 0 10",
                     errs, done, busy);
        end
    endtask

    task automatic test_restart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({busy, done, bus.board_we, bus.board_addr, ship_idx, ship_len} !==
            {1'b1, 1'b0, 1'b1, 7'd0, 2'd0, 3'd4}) begin
            n_bad++;
            $display("FAIL restart got busy/done/we/addr/idx/len=%b%b%b/%0d/%0d/%0d want 101/0/0/4",
                     busy, done, bus.board_we, bus.board_addr, ship_idx, ship_len);
        end
        repeat (100) @(negedge clk);
        n_cmp++;
        if ({bus.board_we, busy} !== 2'b01 || ones_in_board() != 0) begin
            n_bad++;
            $display("FAIL restart_clear got we/busy=%b%b ones=%0d want 01 0",
                     bus.board_we, busy, ones_in_board());
        end
    endtask

    task automatic test_reset_mid_write();
        int errs = 0;
        // Offsets 7..10 are the writes of 32..35; stop after the second has committed.
        do_click(4'd2, 4'd3, 1'b0, 9);
        n_cmp++;
        if ({r_we[8], r_addr[8], r_we[9], r_addr[9]} !== {1'b1, 7'd33, 1'b1, 7'd34}) begin
            n_bad++;
            $display("FAIL midwr_pre got we8/a8/we9/a9=%b/%0d/%b/%0d want 1/33/1/34",
                     r_we[8], r_addr[8], r_we[9], r_addr[9]);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, reject, done, ship_idx, ship_len, bus.board_re, bus.board_we,
             bus.board_wdata, bus.board_addr} !== {3'b000, 2'd0, 3'd4, 3'b000, 7'd0}) begin
            n_bad++;
            $display("FAIL midwr_async got busy/done/we/addr/len=%b%b%b/%0d/%0d want 000/0/4",
                     busy, done, bus.board_we, bus.board_addr, ship_len);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_click(4'd5, 4'd5, 1'b0, 10);
        for (int c = 1; c <= 10; c++) begin
            if (r_re[c] !== 1'b0 || r_we[c] !== 1'b0 || r_rej[c] !== 1'b0) errs++;
        end
        n_cmp++;
        if (errs != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midwr_idle got %0d active cycles busy=%b want 0 0", errs, busy);
        end
        n_cmp++;
        if ({mem[32], mem[33], mem[34], mem[35]} !== 4'b1100) begin
            n_bad++;
            $display("FAIL midwr_ram got %b%b%b%b want 1100", mem[32], mem[33], mem[34], mem[35]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_clear();
        test_reject("bounds_h", 4'd7, 4'd0, 1'b0, 4, 0, 0, 0, 2'd0);
        test_reject("y_range", 4'd0, 4'd10, 1'b0, 4, 0, 0, 0, 2'd0);
        test_place_ship("ship0", 4'd2, 4'd3, 1'b0, 4, 32, 1, 2'd1, 3'd3, 1'b0);
        test_reject("collide", 4'd4, 4'd1, 1'b1, 3, 3, 14, 10, 2'd1);
        test_place_ship("ship1", 4'd9, 4'd5, 1'b1, 3, 59, 10, 2'd2, 3'd2, 1'b0);
        test_reject("bounds_v", 4'd0, 4'd9, 1'b1, 2, 0, 0, 0, 2'd2);
        test_place_ship("ship2", 4'd2, 4'd2, 1'b0, 2, 22, 1, 2'd3, 3'd1, 1'b0);
        test_place_ship("ship3", 4'd9, 4'd9, 1'b0, 1, 99, 1, 2'd3, 3'd1, 1'b1);
        test_done_ignore();
        test_restart();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
